// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter
//   Round-robin arbiter sharing one single-port synchronous ROM between NUM_REQ requesters.
//   At most one read is accepted per cycle. Each issued read carries its requester id and an
//   out-of-range flag down a ROM_LAT-deep tag pipeline. The tag meets the ROM data and is
//   returned as a one-cycle response pulse to the owning requester.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   req_valid_i  per-requester read request
//   req_addr_i   packed request addresses, slice k belongs to requester k
//   req_ready_o  one-hot grant; a transfer happens when valid & ready
//   rsp_valid_o  one-hot response pulse
//   rsp_data_o   response data, shared by all requesters
//   rsp_err_o    response belongs to an out-of-range address
//   busy_o       at least one read in flight
//   rom_en_o     ROM read enable
//   rom_addr_o   ROM address
//   rom_rdata_i  ROM read data
module rom_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned ROM_LAT    = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [WIDTH-1:0]              rsp_data_o,
  output logic                          rsp_err_o,
  output logic                          busy_o,
  output logic                          rom_en_o,
  output logic [ADDR_WIDTH-1:0]         rom_addr_o,
  input  logic [WIDTH-1:0]              rom_rdata_i
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DepthExt = DEPTH[ADDR_WIDTH:0];

  logic [IdW-1:0]              r_ptr;
  logic [ROM_LAT-1:0]          r_vld;
  logic [ROM_LAT-1:0]          r_err;
  logic [ROM_LAT-1:0][IdW-1:0] r_id;

  logic                  w_gnt_found;
  logic [IdW-1:0]        w_gnt_id;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic                  w_hs;
  logic                  w_oor;
  logic                  w_out_vld;
  logic                  w_out_err;
  logic [IdW-1:0]        w_out_id;

  // Pick the valid requester with the smallest rotational distance from the pointer.
  always_comb begin
    int unsigned w_ptr;
    int unsigned w_dist;
    int unsigned w_best;
    w_ptr       = 32'(r_ptr);
    w_dist      = 0;
    w_best      = NUM_REQ;
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_gnt_oh    = '0;
    w_gnt_addr  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_dist = (k >= w_ptr) ? (k - w_ptr) : (k + NUM_REQ - w_ptr);
      if (req_valid_i[k] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_gnt_found = 1'b1;
        w_gnt_id    = k[IdW-1:0];
        w_gnt_oh    = '0;
        w_gnt_oh[k] = 1'b1;
        w_gnt_addr  = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Grants are suppressed while reset is held, since the request path is combinational.
  assign w_hs        = w_gnt_found & ~rst_i;
  assign w_oor       = ({1'b0, w_gnt_addr} >= DepthExt);
  assign req_ready_o = w_hs ? w_gnt_oh : '0;
  assign rom_en_o    = w_hs & ~w_oor;
  assign rom_addr_o  = w_hs ? w_gnt_addr : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= (w_gnt_id == IdW'(NUM_REQ - 1)) ? '0 : (w_gnt_id + IdW'(1));
    end
  end

  // Tag pipeline aligned with the ROM read latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld <= '0;
      r_err <= '0;
      r_id  <= '0;
    end else begin
      r_vld[0] <= w_hs;
      r_err[0] <= w_hs & w_oor;
      r_id[0]  <= w_gnt_id;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

  assign w_out_vld = r_vld[ROM_LAT-1];
  assign w_out_err = r_err[ROM_LAT-1];
  assign w_out_id  = r_id[ROM_LAT-1];

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_out_vld && (w_out_id == k[IdW-1:0])) begin
        rsp_valid_o[k] = 1'b1;
      end
    end
  end

  // The ROM was not enabled for an out-of-range read, so its data must not leak out.
  assign rsp_err_o  = w_out_vld & w_out_err;
  assign rsp_data_o = (w_out_vld && !w_out_err) ? rom_rdata_i : '0;
  assign busy_o     = |r_vld;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// tb_rom_rr_arbiter
//   Directed + randomized bench for rom_rr_arbiter (4 requesters, DEPTH 48, ROM_LAT 3).
//   A behavioural model predicts grants from a rotating priority pointer and keeps a queue of
//   expected responses stamped with their due cycle.
module tb_rom_rr_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int D   = 48;
  localparam int AW  = 6;
  localparam int LAT = 3;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [W-1:0]    rsp_data;
  logic            rsp_err;
  logic            busy;
  logic            rom_en;
  logic [AW-1:0]   rom_addr;
  logic [W-1:0]    rom_rdata;

  rom_rr_arbiter #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .DEPTH     (D),
    .ADDR_WIDTH(AW),
    .ROM_LAT   (LAT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_addr_i (req_addr),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid),
    .rsp_data_o (rsp_data),
    .rsp_err_o  (rsp_err),
    .busy_o     (busy),
    .rom_en_o   (rom_en),
    .rom_addr_o (rom_addr),
    .rom_rdata_i(rom_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] romf(input int a);
    return W'((a * 40503) ^ 23130);
  endfunction

  // ROM model: registered read with LAT cycles latency; junk when not enabled.
  logic [W-1:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_en ? romf(int'(rom_addr)) : 16'hDEAD;
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_rdata = rom_pipe[LAT-1];

  // Requester drive state.
  logic [N-1:0]  v;
  logic [AW-1:0] a [N];
  always_comb begin
    req_valid = v;
    req_addr  = '0;
    for (int k = 0; k < N; k++) req_addr[k*AW +: AW] = a[k];
  end

  typedef struct {
    int           due;
    int           id;
    logic         err;
    logic [W-1:0] data;
  } rsp_t;

  rsp_t q[$];
  int   m_ptr;
  int   cyc;
  int   last_gnt;
  int   total;
  int   bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_gnt();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int           g;
    logic [N-1:0] er;
    logic [N-1:0] ev;
    logic         ee;
    logic [W-1:0] ed;
    rsp_t         e;
    g = -1;
    @(negedge clk);
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_rom_en", 32'(rom_en), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_busy", 32'(busy), 0);
    end else begin
      g  = model_gnt();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("ready", 32'(req_ready), 32'(er));
      chk("rom_en", 32'(rom_en), 32'((g >= 0) && (int'(a[g]) < D)));
      chk("rom_addr", 32'(rom_addr), (g >= 0) ? 32'(a[g]) : 0);
      chk("busy", 32'(busy), 32'(q.size() != 0));
      ev = '0;
      ee = 1'b0;
      ed = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        ev[q[0].id] = 1'b1;
        ee = q[0].err;
        ed = q[0].data;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("rsp_err", 32'(rsp_err), 32'(ee));
      chk("rsp_data", 32'(rsp_data), 32'(ed));
    end
    @(posedge clk);
    if (!rst) begin
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      if (g >= 0) begin
        e.due  = cyc + LAT;
        e.id   = g;
        e.err  = (int'(a[g]) >= D);
        e.data = e.err ? '0 : romf(int'(a[g]));
        q.push_back(e);
        m_ptr = (g + 1) % N;
      end
    end
    last_gnt = g;
    cyc++;
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    cyc      = 0;
    m_ptr    = 0;
    last_gnt = -1;
    rst      = 1'b1;
    v        = '1;
    for (int k = 0; k < N; k++) a[k] = AW'($urandom_range(D - 1));

    // Reset held two cycles with every request up.
    drain(2);
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'h1);
    v = '0;
    drain(1);

    // Requester 2 sweeps the whole address space, including out-of-range words.
    v = 4'b0100;
    for (int ad = 0; ad < 64; ad++) begin
      a[2] = AW'(ad);
      cycle();
    end
    v = '0;
    drain(LAT + 1);

    // All four requesters continuously valid.
    v = '1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (last_gnt >= 0) a[last_gnt] = AW'($urandom_range(63));
    end
    v = '0;
    drain(LAT + 1);

    // Sparse contention: a lone grant to 1 leaves the pointer at 2, then 1 and 3 compete.
    v    = 4'b0010;
    a[1] = AW'($urandom_range(D - 1));
    cycle();
    v    = 4'b1010;
    a[3] = AW'($urandom_range(D - 1));
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (last_gnt >= 0) a[last_gnt] = AW'($urandom_range(D - 1));
    end
    v = '0;
    drain(LAT + 1);

    // Out-of-range request from requester 0.
    v    = 4'b0001;
    a[0] = AW'(50);
    cycle();
    v = '0;
    drain(LAT + 1);

    // Reset in the middle of three in-flight reads.
    v = '1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (last_gnt >= 0) a[last_gnt] = AW'($urandom_range(D - 1));
    end
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_ready", 32'(req_ready), 0);
    q.delete();
    m_ptr = 0;
    drain(2);
    rst = 1'b0;
    v   = '0;
    drain(LAT + 2);

    // Random traffic; held requests keep their address until granted.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!v[k] && $urandom_range(2) == 0) begin
          v[k] = 1'b1;
          a[k] = AW'($urandom_range(63));
        end
      end
      cycle();
      if (last_gnt >= 0) v[last_gnt] = 1'b0;
    end
    v = '0;
    drain(LAT + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
